shared_adder_arb: RTL and testbench

- Round-robin arbiter and sequencer that time-shares one registered adder among NREQ requesters.
- Each requester offers an operand pair over a valid/ready handshake.
- The block grants at most one requester per cycle and registers the sum in a one-entry output slot.
- The result is returned tagged with the requester index, under consumer backpressure.
- Sits between multiple datapath clients and the common adder resource.

---
 rtl/shared_adder_arb.sv | 122 ++++++++++++
 tb/tb_shared_adder_arb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/shared_adder_arb.sv
// shared_adder_arb: round-robin arbiter that time-shares one registered adder
// among NREQ requesters. The winning operand pair is summed into a one-entry
// output slot, which is tagged with the requester index and drained under
// consumer backpressure.
// Optional build macro SHARED_ADDER_ARB_STATS_EN adds per-requester grant
// counters and a stall counter. Arbitration and timing are the same with or
// without it.
module shared_adder_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  output logic [WIDTH:0]        res_sum,
  output logic [ID_W-1:0]       res_id,
  input  logic                  res_ready
`ifdef SHARED_ADDER_ARB_STATS_EN
  ,
  output logic [NREQ*8-1:0]     grant_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {EMPTY, FULL} slot_e;

  slot_e             state, state_nxt;
  logic [ID_W-1:0]   ptr;
  logic              can_accept;
  logic              xfer;
  logic [IW-1:0]     grant_idx;
  logic [WIDTH-1:0]  a_sel, b_sel;

  assign res_valid  = (state == FULL);
  assign can_accept = !res_valid || res_ready;

  // Round-robin search from the pointer upward, wrapping; picks the winner's operands.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    req_ready = '0;
    xfer      = 1'b0;
    grant_idx = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int k = 0; k < NREQ; k++) begin
      int            pos;
      logic [IW-1:0] idx;
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = IW'(pos);
      if (!rst && can_accept && !xfer && req_valid[idx]) begin
        req_ready[idx] = 1'b1;
        xfer           = 1'b1;
        grant_idx      = idx;
        a_sel          = req_a[pos*WIDTH +: WIDTH];
        b_sel          = req_b[pos*WIDTH +: WIDTH];
      end
    end
  end

  // Slot next-state: a grant fills it, a stalled full slot holds, otherwise it empties.
  always_comb begin
    state_nxt = EMPTY;
    if (xfer)                              state_nxt = FULL;
    else if (state == FULL && !res_ready)  state_nxt = FULL;
  end

  // Slot state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Result slot and round-robin pointer load only on a transfer; otherwise they hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_sum <= '0;
      res_id  <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      res_sum <= {1'b0, a_sel} + {1'b0, b_sel};
      res_id  <= ID_W'(grant_idx);
      ptr     <= (grant_idx == IW'(NREQ - 1)) ? '0 : ID_W'(grant_idx) + ID_W'(1);
    end
  end

`ifdef SHARED_ADDER_ARB_STATS_EN
  logic [7:0]  gcnt [NREQ];
  logic [15:0] stall;

  // Saturating per-requester grant counters and a saturating stall-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this small counter array is flop-based, so it is cleared in reset like any register.
      for (int i = 0; i < NREQ; i++) gcnt[i] <= '0;
      stall <= '0;
    end else begin
      if (xfer && gcnt[grant_idx] != 8'hFF) gcnt[grant_idx] <= gcnt[grant_idx] + 8'd1;
      if (res_valid && !res_ready && stall != 16'hFFFF) stall <= stall + 16'd1;
    end
  end

  // Pack the counter array onto the flat output bus.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) grant_cnt[i*8 +: 8] = gcnt[i];
  end

  assign stall_cnt = stall;
`else
  // Default build: no statistics ports or counters.
`endif

endmodule

// File: tb/tb_shared_adder_arb.sv
// Directed self-checking bench for shared_adder_arb (NREQ=4, WIDTH=8, ID_W=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1-2 time
// units after the edge.
module tb_shared_adder_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic [WIDTH:0]        res_sum;
  logic [ID_W-1:0]       res_id;
  logic                  res_ready;
`ifdef SHARED_ADDER_ARB_STATS_EN
  logic [NREQ*8-1:0]     grant_cnt;
  logic [15:0]           stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  shared_adder_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_sum   (res_sum),
    .res_id    (res_id),
    .res_ready (res_ready)
`ifdef SHARED_ADDER_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;

    // Reset state; grants stay off while reset is high even with requests present.
    tick();
    req_valid = 4'b1111;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_sum",   32'(res_sum),   32'h0);
    check("rst_res_id",    32'(res_id),    32'h0);
    tick();
    req_valid = '0;
    rst = 1'b0;

    // Single request: 5 + 3 from requester 0.
    req_valid = 4'b0001;
    set_op(0, 8'h05, 8'h03);
    res_ready = 1'b1;
    #1;
    check("t1_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("t1_res_valid", 32'(res_valid), 32'h1);
    check("t1_res_sum",   32'(res_sum),   32'h008);
    check("t1_res_id",    32'(res_id),    32'h0);
    tick();
    check("t1_drain_valid", 32'(res_valid), 32'h0);
    check("t1_drain_sum",   32'(res_sum),   32'h008);

    // Return the pointer to 0, then all requesters valid: order 0,1,2,3,0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    req_a = {4{8'hFF}};
    req_b = {4{8'h01}};
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_req_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      tick();
      check($sformatf("rr_res_valid_%0d", k), 32'(res_valid), 32'h1);
      check($sformatf("rr_res_sum_%0d", k),   32'(res_sum),   32'h100);
      check($sformatf("rr_res_id_%0d", k),    32'(res_id),    32'(k % 4));
    end

    // Pointer is 1: fill slot from requester 1, then stall 3 cycles with requester 2 waiting.
    req_valid = 4'b0010;
    set_op(1, 8'h10, 8'h20);
    tick();
    check("bp_fill_id",  32'(res_id),  32'h1);
    check("bp_fill_sum", 32'(res_sum), 32'h030);
    res_ready = 1'b0;
    req_valid = 4'b0100;
    set_op(2, 8'h7F, 8'h80);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_req_ready_%0d", k), 32'(req_ready), 32'h0);
      check($sformatf("bp_res_valid_%0d", k), 32'(res_valid), 32'h1);
      check($sformatf("bp_res_sum_%0d", k),   32'(res_sum),   32'h030);
      check($sformatf("bp_res_id_%0d", k),    32'(res_id),    32'h1);
      tick();
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'h4);
    tick();
    check("bp_after_id",  32'(res_id),  32'h2);
    check("bp_after_sum", 32'(res_sum), 32'h0FF);

    // Pointer is 3: requesters 0 and 1 valid -> wrap to 0, then 1.
    req_valid = 4'b0011;
    set_op(0, 8'h01, 8'h02);
    set_op(1, 8'h80, 8'h80);
    #1;
    check("wrap_ready0", 32'(req_ready), 32'h1);
    tick();
    check("wrap_id0",  32'(res_id),  32'h0);
    check("wrap_sum0", 32'(res_sum), 32'h003);
    #1;
    check("wrap_ready1", 32'(req_ready), 32'h2);
    tick();
    check("wrap_id1",  32'(res_id),  32'h1);
    check("wrap_sum1", 32'(res_sum), 32'h100);

    // Fill slot from requester 2, then assert reset mid-cycle.
    req_valid = 4'b0100;
    set_op(2, 8'h11, 8'h22);
    tick();
    check("mid_fill_valid", 32'(res_valid), 32'h1);
    check("mid_fill_sum",   32'(res_sum),   32'h033);
    req_valid = '0;
    res_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'h0);
    check("mid_rst_sum",   32'(res_sum),   32'h0);
    tick();
    rst = 1'b0;
    req_valid = 4'b0110;
    set_op(1, 8'hA0, 8'h0B);
    res_ready = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h2);
    tick();
    check("post_rst_id",  32'(res_id),  32'h1);
    check("post_rst_sum", 32'(res_sum), 32'h0AB);

`ifdef SHARED_ADDER_ARB_STATS_EN
    // 300 grants to requester 2 saturate its counter; then 5 stalled cycles.
    req_valid = 4'b0100;
    for (int k = 0; k < 300; k++) tick();
    check("stat_gcnt2", 32'(grant_cnt[23:16]), 32'd255);
    check("stat_gcnt1", 32'(grant_cnt[15:8]),  32'd1);
    check("stat_gcnt0", 32'(grant_cnt[7:0]),   32'd0);
    req_valid = '0;
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("stat_stall", 32'(stall_cnt), 32'd5);
    res_ready = 1'b1;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
